sram_word_controller: RTL and testbench

Multi-cycle controller that sequences the core's 32-bit data-memory accesses onto an external 16-bit asynchronous SRAM. It sits between the MEM pipeline stage and the SRAM pins. It splits each word access into a low-half and a high-half phase with programmable wait states. While an access is in flight it deasserts `ready`, and the core uses `~ready` as its pipeline freeze.

---
 rtl/sram_word_controller.sv | 176 +++++++++++++++++
 tb/tb_sram_word_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_controller.sv
// sram_word_controller
//   Sequences 32-bit data-memory accesses from the MEM stage onto a 16-bit
//   asynchronous SRAM. Each word access runs as a low-half phase followed by
//   a high-half phase. Each phase is WAIT_CYCLES+1 cycles long. A one-cycle
//   DONE state then releases the core.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   rd_en_i/wr_en_i  request from MEM stage, held until ready_o
//   address_i        byte address (bits [1:0] ignored, wraps modulo SRAM size)
//   write_data_i     store data
//   read_data_o      registered load result, valid from DONE onward
//   ready_o          combinational; low while an access is in flight
//   sram_addr_o      half-word address to SRAM
//   sram_dq_out_o    data driven to SRAM
//   sram_dq_oe_o     1 = controller drives SRAM data bus
//   sram_we_n_o      SRAM write strobe, active low
//   sram_dq_in_i     data returned from SRAM
module sram_word_controller #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [31:0]       address_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic              ready_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [15:0]       sram_dq_out_o,
  output logic              sram_dq_oe_o,
  output logic              sram_we_n_o,
  input  logic [15:0]       sram_dq_in_i
);

  // Last count value of a phase (P-1).
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-2:0]   addr_q, addr_d;     // word address = address[ADDR_W:2]
  logic [31:0]         wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [15:0]         lo_q, lo_d;         // low half captured during a read
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                oe_q, oe_d;
  logic                we_n_q, we_n_d;

  logic req;
  logic phase_end;
  logic accept;

  assign req       = rd_en_i | wr_en_i;
  assign phase_end = (cnt_q == LAST);
  assign accept    = (state_q == IDLE) && req;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_i[31:ADDR_W+1], address_i[1:0]};

  // ---------------------------------------------------------------------
  // State register (also holds latched request and all registered outputs)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      lo_q        <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: if (req) state_d = LOW;
      LOW:  if (phase_end) state_d = HIGH;
      HIGH: if (phase_end) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == LOW || state_q == HIGH) && !phase_end)
      cnt_d = cnt_q + 4'd1;
  end

  // ---------------------------------------------------------------------
  // Output / datapath logic
  // SRAM pins are registered and decoded from the *next* state and count,
  // so they line up with state_q in the cycle they are seen. The only core
  // inputs reaching them pass through the request latch first.
  // ---------------------------------------------------------------------
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = 1'b0;
    we_n_d      = 1'b1;

    if (accept) begin
      addr_d  = address_i[ADDR_W:2];
      wdata_d = write_data_i;
      is_wr_d = wr_en_i;             // write wins when both are requested
    end

    if (state_q == LOW && phase_end && !is_wr_q)
      lo_d = sram_dq_in_i;
    if (state_q == HIGH && phase_end && !is_wr_q)
      rdata_d = {sram_dq_in_i, lo_q};

    // Strobe rises on the last phase cycle while address/data stay put.
    unique case (state_d)
      LOW: begin
        sram_addr_d = {addr_d, 1'b0};
        oe_d        = is_wr_d;
        we_n_d      = !(is_wr_d && cnt_d != LAST);
        if (is_wr_d) dq_out_d = wdata_d[15:0];
      end
      HIGH: begin
        sram_addr_d = {addr_d, 1'b1};
        oe_d        = is_wr_d;
        we_n_d      = !(is_wr_d && cnt_d != LAST);
        if (is_wr_d) dq_out_d = wdata_d[31:16];
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    unique case (state_q)
      IDLE:    ready_o = !req;
      DONE:    ready_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  assign read_data_o   = rdata_q;
  assign sram_addr_o   = sram_addr_q;
  assign sram_dq_out_o = dq_out_q;
  assign sram_dq_oe_o  = oe_q;
  assign sram_we_n_o   = we_n_q;

endmodule

// File: tb/tb_sram_word_controller.sv
module tb_sram_word_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT with WAIT_CYCLES=2 (P=3) ----------------
  logic        rd2 = 0, wr2 = 0;
  logic [31:0] addr2 = 0, wd2 = 0;
  logic [31:0] rdata2;
  logic        ready2;
  logic [17:0] sa2;
  logic [15:0] dq2, din2;
  logic        oe2, we2;
  logic [15:0] mem2 [0:(1<<18)-1];
  logic        prev_we2 = 1'b1;

  sram_word_controller #(.ADDR_W(18), .WAIT_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd2), .wr_en_i(wr2),
    .address_i(addr2), .write_data_i(wd2), .read_data_o(rdata2),
    .ready_o(ready2), .sram_addr_o(sa2), .sram_dq_out_o(dq2),
    .sram_dq_oe_o(oe2), .sram_we_n_o(we2), .sram_dq_in_i(din2));

  // ---------------- DUT with WAIT_CYCLES=1 (P=2) ----------------
  logic        rd1 = 0, wr1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0;
  logic [31:0] rdata1;
  logic        ready1;
  logic [17:0] sa1;
  logic [15:0] dq1, din1;
  logic        oe1, we1;
  logic [15:0] mem1 [0:(1<<18)-1];
  logic        prev_we1 = 1'b1;

  sram_word_controller #(.ADDR_W(18), .WAIT_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd1), .wr_en_i(wr1),
    .address_i(addr1), .write_data_i(wd1), .read_data_o(rdata1),
    .ready_o(ready1), .sram_addr_o(sa1), .sram_dq_out_o(dq1),
    .sram_dq_oe_o(oe1), .sram_we_n_o(we1), .sram_dq_in_i(din1));

  // Async SRAM models: a write lands on the strobe's rising edge, and only
  // if the controller is still driving the bus at that moment.
  assign din2 = mem2[sa2];
  assign din1 = mem1[sa1];
  always @(negedge clk) begin
    prev_we2 <= we2;
    if (!prev_we2 && we2 && oe2) mem2[sa2] <= dq2;
    prev_we1 <= we1;
    if (!prev_we1 && we1 && oe1) mem1[sa1] <= dq1;
  end

  // Counts cycles with ready low until ready rises; -1 on timeout.
  task automatic wait_done2(output int n);
    bit got = 0;
    n = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ready2) got = 1; else n++;
    end
    if (!got) n = -1;
  endtask

  task automatic wait_done1(output int n);
    bit got = 0;
    n = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ready1) got = 1; else n++;
    end
    if (!got) n = -1;
  endtask

  task automatic test_reset();
    rst = 1; rd2 = 0; wr2 = 0; rd1 = 0; wr1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata2); end
    checks++; if (sa2 !== 18'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sa2); end
    checks++; if (dq2 !== 16'h0) begin errors++; $display("FAIL reset_dq got %h exp 0", dq2); end
    checks++; if (oe2 !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", oe2); end
    checks++; if (we2 !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", we2); end
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready2); end
    checks++; if (ready1 !== 1'b1 || we1 !== 1'b1) begin errors++; $display("FAIL reset_dut1 ready %b we_n %b exp 1 1", ready1, we1); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_write();
    logic [17:0] ea; logic [15:0] ed; logic ew;
    @(posedge clk); #1 wr2 = 1; addr2 = 32'h40; wd2 = 32'hDEADBEEF;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ea = (c < 3) ? 18'h20 : 18'h21;
      ed = (c < 3) ? 16'hBEEF : 16'hDEAD;
      ew = ((c % 3) == 2);
      checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL wr_ready c%0d got %b exp 0", c, ready2); end
      checks++; if (sa2 !== ea) begin errors++; $display("FAIL wr_addr c%0d got %h exp %h", c, sa2, ea); end
      checks++; if (dq2 !== ed || oe2 !== 1'b1) begin errors++; $display("FAIL wr_dq c%0d got %h oe %b exp %h 1", c, dq2, oe2, ed); end
      checks++; if (we2 !== ew) begin errors++; $display("FAIL wr_we_n c%0d got %b exp %b", c, we2, ew); end
    end
    @(negedge clk);
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL wr_done_ready got %b exp 1", ready2); end
    checks++; if (we2 !== 1'b1 || oe2 !== 1'b0 || sa2 !== 18'h21 || dq2 !== 16'hDEAD) begin
      errors++; $display("FAIL wr_done_pins we_n %b oe %b addr %h dq %h exp 1 0 21 dead", we2, oe2, sa2, dq2); end
    wr2 = 0;
    @(posedge clk); #1;
    checks++; if (mem2[18'h20] !== 16'hBEEF || mem2[18'h21] !== 16'hDEAD) begin
      errors++; $display("FAIL wr_mem got %h %h exp beef dead", mem2[18'h20], mem2[18'h21]); end
  endtask

  task automatic test_read();
    logic [17:0] ea;
    @(posedge clk); #1 rd2 = 1; addr2 = 32'h40;
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ea = (c < 3) ? 18'h20 : 18'h21;
      checks++; if (ready2 !== 1'b0 || we2 !== 1'b1 || oe2 !== 1'b0 || sa2 !== ea) begin
        errors++; $display("FAIL rd_phase c%0d ready %b we_n %b oe %b addr %h exp 0 1 0 %h", c, ready2, we2, oe2, sa2, ea); end
    end
    @(negedge clk);
    checks++; if (ready2 !== 1'b1 || rdata2 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_done ready %b data %h exp 1 deadbeef", ready2, rdata2); end
    rd2 = 0;
  endtask

  task automatic test_simultaneous();
    int n;
    @(posedge clk); #1 rd2 = 1; wr2 = 1; addr2 = 32'h80; wd2 = 32'h12345678;
    @(posedge clk);
    wait_done2(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL sim_latency got %0d exp 6", n); end
    checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_rdata got %h exp deadbeef", rdata2); end
    rd2 = 0; wr2 = 0;
    @(posedge clk); #1;
    checks++; if (mem2[18'h40] !== 16'h5678 || mem2[18'h41] !== 16'h1234) begin
      errors++; $display("FAIL sim_mem got %h %h exp 5678 1234", mem2[18'h40], mem2[18'h41]); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk); #1 rd2 = 1; addr2 = 32'h80;
    @(posedge clk);
    wait_done2(n);
    checks++; if (rdata2 !== 32'h12345678) begin errors++; $display("FAIL b2b_first got %h exp 12345678", rdata2); end
    addr2 = 32'h40;                       // request stays high across DONE
    @(negedge clk);                       // IDLE: request seen as new
    checks++; if (ready2 !== 1'b0 || sa2 !== 18'h41) begin
      errors++; $display("FAIL b2b_idle ready %b addr %h exp 0 41", ready2, sa2); end
    @(negedge clk);                       // LOW of second access
    checks++; if (sa2 !== 18'h20 || ready2 !== 1'b0) begin
      errors++; $display("FAIL b2b_second_low addr %h ready %b exp 20 0", sa2, ready2); end
    rd2 = 0;                              // dropped mid-access: must still complete
    wait_done2(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_remaining got %0d exp 5", n); end
    checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_second got %h exp deadbeef", rdata2); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 wr2 = 1; addr2 = 32'h80; wd2 = 32'hCAFEF00D;
    @(posedge clk);
    repeat (5) @(negedge clk);            // HIGH, cnt=1
    checks++; if (we2 !== 1'b0 || oe2 !== 1'b1 || sa2 !== 18'h41) begin
      errors++; $display("FAIL mid_pre we_n %b oe %b addr %h exp 0 1 41", we2, oe2, sa2); end
    rst = 1; wr2 = 0;
    @(negedge clk);
    checks++; if (we2 !== 1'b1 || oe2 !== 1'b0) begin errors++; $display("FAIL mid_pins we_n %b oe %b exp 1 0", we2, oe2); end
    checks++; if (ready2 !== 1'b1 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL mid_state ready %b rdata %h exp 1 0", ready2, rdata2); end
    @(posedge clk); #1 rst = 0;
    checks++; if (mem2[18'h40] !== 16'hF00D || mem2[18'h41] !== 16'h1234) begin
      errors++; $display("FAIL mid_mem got %h %h exp f00d 1234", mem2[18'h40], mem2[18'h41]); end
  endtask

  task automatic test_param_edge();
    int n;
    logic [17:0] ea; logic ew;
    @(posedge clk); #1 wr1 = 1; addr1 = 32'h7FFFC; wd1 = 32'h0BADCAFE;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ea = (c < 2) ? 18'h3FFFE : 18'h3FFFF;
      ew = ((c % 2) == 1);
      checks++; if (ready1 !== 1'b0 || sa1 !== ea || we1 !== ew) begin
        errors++; $display("FAIL p1_wr c%0d ready %b addr %h we_n %b exp 0 %h %b", c, ready1, sa1, we1, ea, ew); end
    end
    @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL p1_wr_done got %b exp 1", ready1); end
    wr1 = 0;
    @(posedge clk); #1 rd1 = 1; addr1 = 32'h8007FFFC;   // upper bits wrap away
    @(posedge clk);
    wait_done1(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL p1_rd_latency got %0d exp 4", n); end
    checks++; if (rdata1 !== 32'h0BADCAFE) begin errors++; $display("FAIL p1_rd_data got %h exp 0badcafe", rdata1); end
    rd1 = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_param_edge();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
